// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states and
// the owner encoding used to tag which requester holds the memory.
package dmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. On a tie the requester not granted last
// wins; the last-grant flop only moves when grant_en accepts a grant.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (last == OWN_DBG) ? 2'b01 : 2'b10;
  end

  // Reset value points at dbg so cpu wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  last <= OWN_DBG;
    else if (grant_en && |req) last <= gnt[1];
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous data memory between the cpu MEM stage and a
// debug/loader port; each access is sequenced IDLE->ISSUE->WAIT->RESP.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  state_e           state;
  logic             own;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       gnt;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      ({dbg_req, cpu_req}),
    .grant_en (state == IDLE),
    .gnt      (gnt)
  );

  assign cpu_stall = cpu_req & ~cpu_ack;

  // The command is latched straight into the mem_* registers so they
  // are valid in ISSUE and keep the last command afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      own       <= OWN_CPU;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      mem_en  <= 1'b0;
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      case (state)
        IDLE: if (|gnt) begin
          own       <= gnt[1];
          mem_we    <= gnt[1] ? dbg_we    : cpu_we;
          mem_addr  <= gnt[1] ? dbg_addr  : cpu_addr;
          mem_wdata <= gnt[1] ? dbg_wdata : cpu_wdata;
          mem_en    <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: if (mem_we) begin
          cpu_ack <= (own == OWN_CPU);
          dbg_ack <= (own == OWN_DBG);
          state   <= RESP;
        end else begin
          cnt   <= CNT_W'(MEM_LAT - 1);
          state <= WAIT;
        end
        WAIT: if (cnt == '0) begin
          if (own == OWN_DBG) dbg_rdata <= mem_rdata;
          else                cpu_rdata <= mem_rdata;
          cpu_ack <= (own == OWN_CPU);
          dbg_ack <= (own == OWN_DBG);
          state   <= RESP;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: three instances (MEM_LAT 1, 2, 4) each with
// a latency-accurate memory; only the selected instance sees requests.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
  int          sel = 1;

  logic [31:0] cpu_rdata_w [3], dbg_rdata_w [3], mem_addr_w [3], mem_wdata_w [3], mem_rdata_w [3];
  logic        cpu_ack_w [3], dbg_ack_w [3], cpu_stall_w [3], mem_en_w [3], mem_we_w [3];

  int          lat_of [3] = '{1, 2, 4};
  logic [31:0] sb [3][8];
  int          n_tests = 0;
  int          n_fail  = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    logic [31:0] mem  [8];
    logic [31:0] pipe [4];

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) u_dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req && sel == g), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata_w[g]), .cpu_ack(cpu_ack_w[g]), .cpu_stall(cpu_stall_w[g]),
      .dbg_req(dbg_req && sel == g), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata_w[g]), .dbg_ack(dbg_ack_w[g]),
      .mem_en(mem_en_w[g]), .mem_we(mem_we_w[g]), .mem_addr(mem_addr_w[g]),
      .mem_wdata(mem_wdata_w[g]), .mem_rdata(mem_rdata_w[g])
    );

    // Read data is valid exactly L cycles after the mem_en cycle; junk otherwise.
    always @(posedge clk) begin
      if (mem_en_w[g] && mem_we_w[g]) mem[mem_addr_w[g][4:2]] <= mem_wdata_w[g];
      pipe[0] <= (mem_en_w[g] && !mem_we_w[g]) ? mem[mem_addr_w[g][4:2]] : $urandom;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata_w[g] = pipe[L-1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end else begin
      dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  // Reset holds all outputs at 0 even with a request pending; release starts a read.
  task automatic test_reset();
    logic [3:0] obs, ex;
    sel = 1;
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h0C, '0);
    repeat (3) tick();
    @(negedge clk);
    n_tests++;
    if ({mem_en_w[1], mem_we_w[1], cpu_ack_w[1], dbg_ack_w[1], mem_addr_w[1], mem_wdata_w[1],
         cpu_rdata_w[1], dbg_rdata_w[1]} !== '0)
      begin n_fail++; $display("FAIL reset_outputs: got en=%b ack=%b addr=%h want all zero",
                               mem_en_w[1], cpu_ack_w[1], mem_addr_w[1]); end
    tick();
    rst = 1'b1;
    for (int t = 0; t <= 6; t++) begin
      @(negedge clk);
      obs = {mem_en_w[1], cpu_ack_w[1], dbg_ack_w[1], cpu_stall_w[1]};
      ex  = {(t == 1), (t == 4), 1'b0, (t < 4)};
      n_tests++;
      if (obs !== ex) begin n_fail++; $display("FAIL reset_release c%0d: got %b want %b", t, obs, ex); end
      tick();
      if (t == 4) drive(0, 1'b0, 1'b0, '0, '0);
    end
  endtask

  // One transaction on port p of instance kk, checked cycle by cycle.
  task automatic test_single(input int kk, input int p, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata);
    int exp_t;
    logic [3:0]  obs, ex;
    logic [31:0] rd;
    sel   = kk;
    exp_t = we ? 2 : 2 + lat_of[kk];
    drive(p, 1'b1, we, addr, wdata);
    for (int t = 0; t <= exp_t + 1; t++) begin
      @(negedge clk);
      obs = {mem_en_w[kk], cpu_ack_w[kk], dbg_ack_w[kk], cpu_stall_w[kk]};
      ex  = {(t == 1), (p == 0 && t == exp_t), (p == 1 && t == exp_t), (p == 0 && t < exp_t)};
      n_tests++;
      if (obs !== ex) begin
        n_fail++; $display("FAIL single_timing lat%0d p%0d we%0d c%0d: got %b want %b",
                           lat_of[kk], p, we, t, obs, ex);
      end
      if (t == 1) begin
        n_tests++;
        if (mem_we_w[kk] !== we || mem_addr_w[kk] !== addr || (we && mem_wdata_w[kk] !== wdata)) begin
          n_fail++; $display("FAIL single_cmd lat%0d: got we=%b addr=%h wd=%h want we=%b addr=%h wd=%h",
                             lat_of[kk], mem_we_w[kk], mem_addr_w[kk], mem_wdata_w[kk], we, addr, wdata);
        end
      end
      if (t == exp_t && !we) begin
        rd = p ? dbg_rdata_w[kk] : cpu_rdata_w[kk];
        n_tests++;
        if (rd !== sb[kk][addr[4:2]]) begin
          n_fail++; $display("FAIL single_rdata lat%0d p%0d: got %h want %h", lat_of[kk], p, rd, sb[kk][addr[4:2]]);
        end
      end
      tick();
      if (t == exp_t) drive(p, 1'b0, 1'b0, '0, '0);
    end
    if (we) sb[kk][addr[4:2]] = wdata;
  endtask

  task automatic test_rw(input int kk);
    sel = kk;
    do_reset();
    test_single(kk, 1, 1'b1, 32'h0C, 32'hDEADBEEF);
    test_single(kk, 0, 1'b0, 32'h0C, '0);
    test_single(kk, 1, 1'b1, 32'h0C, 32'h12345678);
    test_single(kk, 0, 1'b0, 32'h0C, '0);
    test_single(kk, 1, 1'b0, 32'h0C, '0);
  endtask

  task automatic preload(input int kk);
    for (int i = 0; i < 8; i++) test_single(kk, 1, 1'b1, i << 2, $urandom);
  endtask

  // Both ports held continuously: grants must alternate starting with cpu.
  task automatic test_both();
    int lat = lat_of[1];
    int t = 0, n = 0, exp_t;
    logic        exp_own = 1'b0;
    logic        w [2];
    logic [31:0] a [2], d [2], rd;
    logic [1:0]  obs, ex;
    sel = 1;
    preload(1);
    do_reset();
    for (int p = 0; p < 2; p++) begin
      w[p] = 1'($urandom); a[p] = $urandom & 32'hFFFF_FFFC; d[p] = $urandom;
      drive(p, 1'b1, w[p], a[p], d[p]);
    end
    exp_t = w[0] ? 2 : 2 + lat;
    while (n < 4 && t < 80) begin
      @(negedge clk);
      obs = {dbg_ack_w[1], cpu_ack_w[1]};
      ex  = (t == exp_t) ? (exp_own ? 2'b10 : 2'b01) : 2'b00;
      n_tests++;
      if (obs !== ex) begin n_fail++; $display("FAIL both_ack c%0d: got %b want %b", t, obs, ex); end
      if (t == exp_t) begin
        if (w[exp_own]) sb[1][a[exp_own][4:2]] = d[exp_own];
        else begin
          rd = exp_own ? dbg_rdata_w[1] : cpu_rdata_w[1];
          n_tests++;
          if (rd !== sb[1][a[exp_own][4:2]]) begin
            n_fail++; $display("FAIL both_rdata p%0d: got %h want %h", exp_own, rd, sb[1][a[exp_own][4:2]]);
          end
        end
        n++;
        w[exp_own] = 1'($urandom); a[exp_own] = $urandom & 32'hFFFF_FFFC; d[exp_own] = $urandom;
        exp_own = ~exp_own;
        exp_t   = t + 1 + (w[exp_own] ? 2 : 2 + lat);
      end
      tick();
      if (n < 4) for (int p = 0; p < 2; p++) drive(p, 1'b1, w[p], a[p], d[p]);
      t++;
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    if (n < 4) begin n_tests++; n_fail++; $display("FAIL both_timeout: got %0d acks want 4", n); end
    repeat (3) tick();
  endtask

  // Reset during WAIT abandons the read; a fresh read then completes.
  task automatic test_reset_mid_read();
    logic [2:0] obs;
    sel = 1;
    do_reset();
    test_single(1, 1, 1'b1, 32'h0C, 32'hA5A5_0F0F);
    drive(0, 1'b1, 1'b0, 32'h0C, '0);
    repeat (2) tick();
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      obs = {mem_en_w[1], cpu_ack_w[1], dbg_ack_w[1]};
      n_tests++;
      if (obs !== 3'b000) begin n_fail++; $display("FAIL midreset_quiet c%0d: got %b want 000", t, obs); end
      tick();
      if (t == 2) rst = 1'b1;
    end
    test_single(1, 0, 1'b0, 32'h0C, '0);
  endtask

  // Random traffic on both ports against a transaction-level model.
  task automatic test_random(input int kk, input int ncyc);
    int lat, t = 0, mem_t = 0, ack_t = 0;
    logic        act = 1'b0, last = 1'b1, own = 1'b0;
    logic        pend [2] = '{1'b0, 1'b0};
    logic        w [2];
    logic [31:0] a [2], d [2], rd;
    logic [3:0]  obs, ex;
    logic        fin;
    sel = kk;
    preload(kk);
    do_reset();
    lat = lat_of[kk];
    while (t < ncyc || pend[0] || pend[1] || act) begin
      if (t > ncyc + 100) begin n_tests++; n_fail++; $display("FAIL random_timeout lat%0d", lat); break; end
      for (int p = 0; p < 2; p++)
        if (!pend[p] && t < ncyc && $urandom_range(2) == 0) begin
          pend[p] = 1'b1; w[p] = 1'($urandom); a[p] = $urandom & 32'hFFFF_FFFC; d[p] = $urandom;
          drive(p, 1'b1, w[p], a[p], d[p]);
        end
      if (!act && (pend[0] || pend[1])) begin
        own   = (pend[0] && pend[1]) ? ~last : pend[1];
        last  = own;
        act   = 1'b1;
        mem_t = t + 1;
        ack_t = t + (w[own] ? 2 : 2 + lat);
      end
      @(negedge clk);
      fin = act && t == ack_t;
      obs = {mem_en_w[kk], cpu_ack_w[kk], dbg_ack_w[kk], cpu_stall_w[kk]};
      ex  = {act && t == mem_t, fin && !own, fin && own, pend[0] && !(fin && !own)};
      n_tests++;
      if (obs !== ex) begin n_fail++; $display("FAIL random lat%0d c%0d: got %b want %b", lat, t, obs, ex); end
      if (act && t == mem_t) begin
        n_tests++;
        if (mem_we_w[kk] !== w[own] || mem_addr_w[kk] !== a[own] || (w[own] && mem_wdata_w[kk] !== d[own])) begin
          n_fail++; $display("FAIL random_cmd lat%0d c%0d: got addr=%h want %h", lat, t, mem_addr_w[kk], a[own]);
        end
      end
      if (fin) begin
        if (w[own]) sb[kk][a[own][4:2]] = d[own];
        else begin
          rd = own ? dbg_rdata_w[kk] : cpu_rdata_w[kk];
          n_tests++;
          if (rd !== sb[kk][a[own][4:2]]) begin
            n_fail++; $display("FAIL random_rdata lat%0d c%0d: got %h want %h", lat, t, rd, sb[kk][a[own][4:2]]);
          end
        end
        pend[own] = 1'b0;
        act = 1'b0;
      end
      tick();
      for (int p = 0; p < 2; p++) if (!pend[p]) drive(p, 1'b0, 1'b0, '0, '0);
      t++;
    end
  endtask

  initial begin
    test_reset();
    for (int k = 0; k < 3; k++) test_rw(k);
    test_both();
    test_reset_mid_read();
    for (int k = 0; k < 3; k++) test_random(k, 400);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
